// File: rtl/aes_key_pkg.sv
// Shared AES key-schedule definitions.
// Contents: key-length mode encodings, Nk/Nr lookup per mode, the sequencer
// state enum and the GF(2^8) reduction constant used by xtime.
package aes_key_pkg;

  localparam logic [1:0] MODE_AES128 = 2'b00;
  localparam logic [1:0] MODE_AES192 = 2'b01;
  localparam logic [1:0] MODE_AES256 = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  // x^8 + x^4 + x^3 + x + 1 with the x^8 term dropped
  localparam logic [7:0] GF_POLY = 8'h1B;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Key length in 32-bit words; reserved mode maps to 8 but is never latched
  function automatic logic [3:0] nk_of(input logic [1:0] m);
    case (m)
      MODE_AES128: nk_of = 4'd4;
      MODE_AES192: nk_of = 4'd6;
      default:     nk_of = 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] m);
    case (m)
      MODE_AES128: nr_of = 4'd10;
      MODE_AES192: nr_of = 4'd12;
      default:     nr_of = 4'd14;
    endcase
  endfunction

  // Index of the final expanded-key word: 4*(Nr+1)-1 (43, 51 or 59)
  function automatic logic [5:0] last_idx_of(input logic [1:0] m);
    logic [5:0] nr6;
    nr6 = {2'b00, nr_of(m)};
    last_idx_of = ((nr6 + 6'd1) << 2) - 6'd1;
  endfunction

endpackage

// File: rtl/gf_xtime.sv
// Multiply-by-x in GF(2^8) with the AES polynomial.
// Ports:
//   in  - 8-bit field element
//   out - in * x mod (x^8 + x^4 + x^3 + x + 1)
module gf_xtime
  import aes_key_pkg::*;
(
  input  logic [7:0] in,
  output logic [7:0] out
);

  assign out = {in[6:0], 1'b0} ^ (in[7] ? GF_POLY : 8'h00);

endmodule

// File: rtl/rcon_sequencer.sv
// AES key-expansion beat sequencer. After a start in IDLE it streams one beat
// per expanded-key word i = Nk .. 4*(Nr+1)-1 with the flags telling the
// consumer which transform applies to that word, under valid/ready flow control.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, mode         - begin a sequence for the given key length (11 = error)
//   out_ready           - consumer accepts the current beat
//   out_valid           - beat fields valid
//   word_idx            - expanded-key word index of the beat
//   rcon                - round constant, byte in the top 8 bits, 0 unless rot_sub
//   rot_sub, sub_only   - i mod Nk == 0 / (Nk == 8 and i mod 8 == 4)
//   last                - final beat of the sequence
//   busy, done, err     - RUN state, end-of-sequence pulse, reserved-mode pulse
module rcon_sequencer
  import aes_key_pkg::*;
#(
  parameter int unsigned RCON_W = 32,
  parameter int unsigned IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [IDX_W-1:0]  word_idx,
  output logic [RCON_W-1:0] rcon,
  output logic              rot_sub,
  output logic              sub_only,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e             state_q;
  logic [3:0]         nk_q;
  logic [IDX_W-1:0]   last_idx_q;
  logic [IDX_W-1:0]   idx_q;
  logic [2:0]         phase_q;     // i mod Nk
  logic [7:0]         rcon_byte_q; // constant for the next rot_sub beat
  logic [7:0]         rcon_byte_next;
  logic               done_q;
  logic               err_q;
  logic               xfer;
  logic               phase_wrap;

  gf_xtime u_xtime (
    .in  (rcon_byte_q),
    .out (rcon_byte_next)
  );

  assign busy       = (state_q == RUN);
  assign out_valid  = busy;
  assign xfer       = out_valid && out_ready;
  assign phase_wrap = (phase_q == 3'(nk_q - 4'd1));

  // Beat fields are gated by busy so stale counters never leak out in IDLE
  always_comb begin
    word_idx = busy ? idx_q : '0;
    rot_sub  = busy && (phase_q == 3'd0);
    sub_only = busy && (nk_q == 4'd8) && (phase_q == 3'd4);
    last     = busy && (idx_q == last_idx_q);
    rcon     = '0;
    if (rot_sub) begin
      rcon[RCON_W-1 -: 8] = rcon_byte_q;
    end
  end

  assign done = done_q;
  assign err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      nk_q        <= 4'd0;
      last_idx_q  <= '0;
      idx_q       <= '0;
      phase_q     <= 3'd0;
      rcon_byte_q <= 8'h00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (mode == MODE_RSVD) begin
              err_q <= 1'b1;
            end else begin
              state_q     <= RUN;
              nk_q        <= nk_of(mode);
              last_idx_q  <= IDX_W'(last_idx_of(mode));
              idx_q       <= IDX_W'(nk_of(mode));
              phase_q     <= 3'd0;
              rcon_byte_q <= 8'h01;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            idx_q   <= idx_q + IDX_W'(1);
            phase_q <= phase_wrap ? 3'd0 : phase_q + 3'd1;
            if (phase_q == 3'd0) begin
              rcon_byte_q <= rcon_byte_next;
            end
            if (last) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rcon_sequencer.sv
module tb_rcon_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic        out_ready;
  logic        out_valid;
  logic [5:0]  word_idx;
  logic [31:0] rcon;
  logic        rot_sub;
  logic        sub_only;
  logic        last;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  rcon_sequencer #(
    .RCON_W (32),
    .IDX_W  (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .word_idx  (word_idx),
    .rcon      (rcon),
    .rot_sub   (rot_sub),
    .sub_only  (sub_only),
    .last      (last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_idx"},   64'(word_idx),  64'd0);
    check({tag, "_rcon"},  64'(rcon),      64'd0);
    check({tag, "_rot"},   64'(rot_sub),   64'd0);
    check({tag, "_sub"},   64'(sub_only),  64'd0);
    check({tag, "_last"},  64'(last),      64'd0);
    check({tag, "_busy"},  64'(busy),      64'd0);
    check({tag, "_done"},  64'(done),      64'd0);
    check({tag, "_err"},   64'(err),       64'd0);
  endtask

  task automatic wait_idx(input int target, input string tag);
    int n;
    n = 0;
    while (!(out_valid === 1'b1 && word_idx == 6'(target)) && n < 100) begin
      step();
      n++;
    end
    check({tag, "_reach_idx"}, 64'(word_idx), 64'(target));
  endtask

  task automatic drain(input string tag);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (out_valid === 1'b1 && n < 80) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 64'(out_valid), 64'd0);
    step();
  endtask

  // Full sequence with ready held high; every beat checked against the
  // key-schedule rules computed here from i and Nk.
  task automatic run_full(input logic [1:0] m, input int nk, input int nbeats,
                          input string tag);
    int i;
    int beats;
    int k;
    logic [7:0] exp_byte;
    logic exp_rot;
    logic exp_sub;
    start = 1'b1;
    mode = m;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    i = nk;
    beats = 0;
    while (out_valid === 1'b1 && beats < 80) begin
      exp_rot = (i % nk) == 0;
      k = i / nk - 1;
      exp_byte = (exp_rot && k < 10) ? rcon_tab[k] : 8'h00;
      exp_sub = (nk == 8) && ((i % 8) == 4);
      check({tag, "_idx"},  64'(word_idx), 64'(i));
      check({tag, "_rot"},  64'(rot_sub),  64'(exp_rot));
      check({tag, "_rcon"}, 64'(rcon),     64'(exp_byte) << 24);
      check({tag, "_sub"},  64'(sub_only), 64'(exp_sub));
      check({tag, "_last"}, 64'(last),     64'(beats == nbeats - 1));
      check({tag, "_busy"}, 64'(busy),     64'd1);
      i++;
      beats++;
      step();
    end
    check({tag, "_beats"},     64'(beats),     64'(nbeats));
    check({tag, "_done"},      64'(done),      64'd1);
    check({tag, "_end_valid"}, 64'(out_valid), 64'd0);
    step();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode = 2'b00;
    out_ready = 1'b0;
    #3;
    check_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Full sequences for each key length
    run_full(2'b00, 4, 40, "aes128");
    run_full(2'b01, 6, 46, "aes192");
    run_full(2'b10, 8, 52, "aes256");

    // Backpressure at idx 8 in AES-128
    start = 1'b1;
    mode = 2'b00;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    check("bp_first_idx", 64'(word_idx), 64'd4);
    wait_idx(8, "bp");
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_idx",   64'(word_idx),  64'd8);
      check("bp_hold_rot",   64'(rot_sub),   64'd1);
      check("bp_hold_rcon",  64'(rcon),      64'h0200_0000);
    end
    out_ready = 1'b1;
    step();
    check("bp_resume_idx", 64'(word_idx), 64'd9);
    check("bp_resume_rot", 64'(rot_sub),  64'd0);
    drain("bp");

    // Reserved mode
    start = 1'b1;
    mode = 2'b11;
    step();
    start = 1'b0;
    check("err_pulse", 64'(err),       64'd1);
    check("err_valid", 64'(out_valid), 64'd0);
    check("err_busy",  64'(busy),      64'd0);
    step();
    check("err_clear",  64'(err),       64'd0);
    check("err_valid2", 64'(out_valid), 64'd0);

    // Start during RUN is ignored; start on the last beat is ignored;
    // start in the done cycle is accepted.
    start = 1'b1;
    mode = 2'b00;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("col_idx6", 64'(word_idx), 64'd6);
    start = 1'b1;
    mode = 2'b10;
    step();
    start = 1'b0;
    check("col_ign_idx", 64'(word_idx), 64'd7);
    step();
    check("col_ign_rot",  64'(rot_sub), 64'd1);
    check("col_ign_rcon", 64'(rcon),    64'h0200_0000);
    wait_idx(43, "col");
    check("col_last", 64'(last), 64'd1);
    start = 1'b1;
    mode = 2'b01;
    step();
    check("col_done",        64'(done),      64'd1);
    check("col_done_valid",  64'(out_valid), 64'd0);
    mode = 2'b00;
    step();
    start = 1'b0;
    check("col_restart_valid", 64'(out_valid), 64'd1);
    check("col_restart_idx",   64'(word_idx),  64'd4);
    check("col_restart_rcon",  64'(rcon),      64'h0100_0000);
    drain("col");

    // Reset mid-run
    start = 1'b1;
    mode = 2'b00;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    wait_idx(20, "rst");
    check("rst_pre_rcon", 64'(rcon), 64'h1000_0000);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    step();
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1;
    mode = 2'b10;
    step();
    start = 1'b0;
    check("rst_restart_valid", 64'(out_valid), 64'd1);
    check("rst_restart_idx",   64'(word_idx),  64'd8);
    check("rst_restart_rot",   64'(rot_sub),   64'd1);
    check("rst_restart_rcon",  64'(rcon),      64'h0100_0000);
    drain("rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rcon_sequencer.md
RCON_SEQUENCER -- requirements
Module: rcon_sequencer

Interface
REQ-001 SHALL have parameter RCON_W, default 32: rcon output width, at least 8; the round-constant byte occupies bits [RCON_W-1 -: 8] and all other bits are 0.
REQ-002 SHALL have parameter IDX_W, default 6: word_idx width, at least 6.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: request to begin a key-schedule word sequence.
REQ-006 SHALL have port mode, input, 2 bits: 00 = AES-128 (Nk=4, Nr=10), 01 = AES-192 (Nk=6, Nr=12), 10 = AES-256 (Nk=8, Nr=14), 11 = reserved.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer accepts the current beat.
REQ-008 SHALL have port out_valid, output, 1 bit: beat fields are valid.
REQ-009 SHALL have port word_idx, output, IDX_W bits: expanded-key word index i of the current beat.
REQ-010 SHALL have port rcon, output, RCON_W bits: round constant for this beat, nonzero only when rot_sub=1.
REQ-011 SHALL have port rot_sub, output, 1 bit: i mod Nk == 0, so RotWord, SubWord and Rcon apply.
REQ-012 SHALL have port sub_only, output, 1 bit: Nk == 8 and i mod 8 == 4, so SubWord only applies.
REQ-013 SHALL have port last, output, 1 bit: current beat is i = 4*(Nr+1)-1.
REQ-014 SHALL have ports busy (high while a sequence is active), done (1-cycle pulse) and err (1-cycle pulse), each output, 1 bit.

Function
REQ-015 SHALL have states IDLE and RUN; busy = (state == RUN).
REQ-016 SHALL accept start only in IDLE and latch mode; start while in RUN SHALL be ignored.
REQ-017 SHALL, on start with mode 11, pulse err for 1 cycle the next cycle, stay in IDLE and never assert out_valid.
REQ-018 SHALL, on a valid start, enter RUN and assert out_valid the next cycle with word_idx=Nk, rot_sub=1 and rcon byte 0x01 (latency 1 cycle).
REQ-019 SHALL transfer a beat when out_valid && out_ready; out_valid and all beat fields SHALL stay stable while out_ready=0.
REQ-020 SHALL, on each transfer, increment word_idx and a phase counter modulo Nk that wraps to 0.
REQ-021 SHALL, on transfer of a rot_sub beat, update the rcon byte to xtime(byte): shift left 1, then XOR 0x1B if the old bit 7 was 1.
REQ-022 SHALL sustain 1 beat per cycle while out_ready is held at 1.
REQ-023 SHALL, on transfer of the last beat, return to IDLE, deassert out_valid and pulse done the next cycle; start in the done cycle SHALL be accepted.
REQ-024 SHALL ignore start in the same cycle as the last transfer, because the block is still busy.
REQ-025 SHALL produce beat counts of 40, 46 and 52 for modes 00, 01 and 10.

Reset
REQ-026 SHALL, while rst_n=0, force state IDLE, out_valid=0, word_idx=0, rcon=0, rot_sub=0, sub_only=0, last=0, busy=0, done=0 and err=0 immediately, without waiting for a clock edge.
REQ-027 SHALL abandon an in-progress sequence on reset; after reset release, the next start SHALL restart at word_idx=Nk with rcon byte 0x01.

Structure
REQ-028 SHALL take from shared package aes_key_pkg: mode encodings, Nk/Nr per mode, the state enum and the reduction constant 0x1B.
REQ-029 SHALL instantiate one combinational sub-module, gf_xtime (8-bit in, 8-bit out), for the rcon update.

Verification
REQ-030 SHALL cover AES-128 with ready=1: start mode=00 -> 40 beats, idx 4..43; rot_sub at 4,8,...,40 with rcon 01,02,04,08,10,20,40,80,1B,36; last at 43; done 1 cycle later.
REQ-031 SHALL cover AES-192: mode=01 -> idx 6..51; rot_sub at 6,12,...,48 with rcon 01..80; sub_only never set; last at 51.
REQ-032 SHALL cover AES-256: mode=10 -> idx 8..59; rot_sub at 8,16,...,56 with rcon 01..40; sub_only at 12,20,28,36,44,52; last at 59.
REQ-033 SHALL cover backpressure: out_ready=0 for 5 cycles at idx 8 in mode 00 -> fields frozen (rot_sub=1, rcon byte 0x02), no index skipped, and resume at 9.
REQ-034 SHALL cover errors and collisions: start mode=11 -> err 1-cycle pulse with no valid; start during RUN -> ignored; start in the done cycle -> new first beat 1 cycle later.
REQ-035 SHALL cover reset mid-run: rst_n low at idx 20 -> all outputs 0 asynchronously; after release, start mode=10 -> first beat idx 8 with rcon byte 01.
